// File: rtl/biquad_iir_filter_if.sv
// Sample/coefficient bus for the biquad filter.
// master: coefficient unit + source + sink side; slave: the filter.
interface biquad_iir_filter_if #(
   parameter int SAMPLE_WIDTH = 24
);
   logic                    coeff_valid;
   logic [SAMPLE_WIDTH-1:0] b0_in;
   logic [SAMPLE_WIDTH-1:0] b1_in;
   logic [SAMPLE_WIDTH-1:0] b2_in;
   logic [SAMPLE_WIDTH-1:0] a1_in;
   logic [SAMPLE_WIDTH-1:0] a2_in;
   logic [SAMPLE_WIDTH-1:0] sample_in;
   logic                    sample_valid;
   logic                    sample_ready;
   logic                    flush;
   logic [SAMPLE_WIDTH-1:0] sample_out;
   logic                    out_valid;
   logic                    sat;

   modport master (
      output coeff_valid,
      output b0_in, b1_in, b2_in,
      output a1_in, a2_in,
      output sample_in, sample_valid,
      output flush,
      input  sample_ready,
      input  sample_out, out_valid, sat
   );

   modport slave (
      input  coeff_valid,
      input  b0_in, b1_in, b2_in,
      input  a1_in, a2_in,
      input  sample_in, sample_valid,
      input  flush,
      output sample_ready,
      output sample_out, out_valid, sat
   );
endinterface

// File: rtl/biquad_iir_filter.sv
// Direct Form I biquad, one shared multiplier, 7 cycles/sample.
// Ports: clk, reset (async, active-low), bus (biquad_iir_filter_if.slave).
module biquad_iir_filter #(
   parameter int SAMPLE_WIDTH = 24,
   parameter int FRAC_BITS    = 16,
   parameter int ACC_WIDTH    = 52
) (
   input  logic                 clk,
   input  logic                 reset,
   biquad_iir_filter_if.slave   bus
);

   localparam int W  = SAMPLE_WIDTH;
   localparam int PW = 2 * SAMPLE_WIDTH;

   localparam logic signed [ACC_WIDTH-1:0] Y_MAX =
      {{(ACC_WIDTH-W+1){1'b0}}, {(W-1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] Y_MIN = ~Y_MAX;
   localparam logic signed [ACC_WIDTH-1:0] RND_HALF =
      ACC_WIDTH'(1) << (FRAC_BITS - 1);
   localparam logic [W-1:0] SAT_HI = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0] SAT_LO = {1'b1, {(W-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE,
      MAC,
      ROUND
   } state_t;

   state_t state_q, state_d;
   logic [2:0] k_q;

   // index 0..4 = b0, b1, b2, a1, a2
   logic signed [W-1:0] shadow_q [5];
   logic signed [W-1:0] active_q [5];
   logic                pending_q;

   logic signed [W-1:0] x0_q, x1_q, x2_q;
   logic signed [W-1:0] y1_q, y2_q;
   logic signed [ACC_WIDTH-1:0] acc_q;

   logic [W-1:0] out_q;
   logic         out_valid_q;
   logic         sat_q;

   logic accept;

   logic signed [W-1:0]         mul_c;
   logic signed [W-1:0]         mul_d;
   logic                        mul_sub;
   logic signed [PW-1:0]        prod;
   logic signed [ACC_WIDTH-1:0] prod_ext;
   logic signed [ACC_WIDTH-1:0] acc_next;

   logic signed [ACC_WIDTH-1:0] rnd_sum;
   logic signed [ACC_WIDTH-1:0] rnd_shr;
   logic [W-1:0]                y_sat;
   logic                        clip;

   // ready is gated by reset so it reads 0 while reset is held
   assign bus.sample_ready = reset & (state_q == IDLE);
   assign accept = bus.sample_valid & bus.sample_ready;

   assign bus.sample_out = out_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.sat        = sat_q;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept) state_d = MAC;
         MAC:     if (k_q == 3'd4) state_d = ROUND;
         ROUND:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         k_q     <= '0;
      end else begin
         state_q <= state_d;
         if (accept)
            k_q <= '0;
         else if (state_q == MAC)
            k_q <= k_q + 3'd1;
      end
   end

   // A load on the accept edge lands in shadow after the
   // old shadow was copied, so it waits for the next sample.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 5; i++) begin
            shadow_q[i] <= '0;
            active_q[i] <= '0;
         end
         pending_q <= 1'b0;
      end else begin
         if (accept && pending_q) begin
            for (int i = 0; i < 5; i++)
               active_q[i] <= shadow_q[i];
            pending_q <= 1'b0;
         end
         if (bus.coeff_valid) begin
            shadow_q[0] <= $signed(bus.b0_in);
            shadow_q[1] <= $signed(bus.b1_in);
            shadow_q[2] <= $signed(bus.b2_in);
            shadow_q[3] <= $signed(bus.a1_in);
            shadow_q[4] <= $signed(bus.a2_in);
            pending_q   <= 1'b1;
         end
      end
   end

   always_comb begin
      mul_c   = '0;
      mul_d   = '0;
      mul_sub = 1'b0;
      unique case (k_q)
         3'd0: begin
            mul_c = active_q[0];
            mul_d = x0_q;
         end
         3'd1: begin
            mul_c = active_q[1];
            mul_d = x1_q;
         end
         3'd2: begin
            mul_c = active_q[2];
            mul_d = x2_q;
         end
         3'd3: begin
            mul_c   = active_q[3];
            mul_d   = y1_q;
            mul_sub = 1'b1;
         end
         3'd4: begin
            mul_c   = active_q[4];
            mul_d   = y2_q;
            mul_sub = 1'b1;
         end
         default: begin
            mul_c = '0;
            mul_d = '0;
         end
      endcase
   end

   assign prod = PW'(mul_c) * PW'(mul_d);
   assign prod_ext = {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};
   assign acc_next = mul_sub ? acc_q - prod_ext
                             : acc_q + prod_ext;

   // round half up, then clip to the Q1.23 range
   assign rnd_sum = acc_q + RND_HALF;
   assign rnd_shr = rnd_sum >>> FRAC_BITS;

   always_comb begin
      y_sat = rnd_shr[W-1:0];
      clip  = 1'b0;
      if (rnd_shr > Y_MAX) begin
         y_sat = SAT_HI;
         clip  = 1'b1;
      end else if (rnd_shr < Y_MIN) begin
         y_sat = SAT_LO;
         clip  = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         x0_q  <= '0;
         x1_q  <= '0;
         x2_q  <= '0;
         y1_q  <= '0;
         y2_q  <= '0;
         acc_q <= '0;
      end else begin
         if (accept) begin
            x0_q  <= $signed(bus.sample_in);
            acc_q <= '0;
         end
         if (state_q == MAC)
            acc_q <= acc_next;
         if (state_q == IDLE && bus.flush) begin
            x1_q <= '0;
            x2_q <= '0;
            y1_q <= '0;
            y2_q <= '0;
         end
         if (state_q == ROUND) begin
            x2_q <= x1_q;
            x1_q <= x0_q;
            y2_q <= y1_q;
            y1_q <= $signed(y_sat);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_q       <= '0;
         out_valid_q <= 1'b0;
         sat_q       <= 1'b0;
      end else begin
         out_valid_q <= (state_q == ROUND);
         if (state_q == ROUND) begin
            out_q <= y_sat;
            sat_q <= clip;
         end
      end
   end

endmodule

// File: tb/tb_biquad_iir_filter.sv
// Self-checking bench for biquad_iir_filter.
// Directed test-plan cases, then random samples vs a reference model.
module tb_biquad_iir_filter;

   localparam int W = 24;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   always #5 clk = ~clk;

   biquad_iir_filter_if #(.SAMPLE_WIDTH(W)) bus ();

   biquad_iir_filter #(
      .SAMPLE_WIDTH(W),
      .FRAC_BITS(16),
      .ACC_WIDTH(52)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   int n_chk = 0;
   int n_err = 0;

   // reference model state: coefficients as real-valued
   // Q8.16 integers, history as Q1.23 integers
   longint m_sh[5];
   longint m_act[5];
   bit     m_pend;
   longint m_x1, m_x2, m_y1, m_y2;
   longint nc[5];

   task automatic check(string tag, logic [63:0] obs,
                        logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
      end
   endtask

   function automatic longint sx(logic [23:0] v);
      return longint'($signed(v));
   endfunction

   function automatic longint rc();
      logic [17:0] r;
      r = 18'($urandom);
      return sx({{6{r[17]}}, r});
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 5; i++) begin
         m_sh[i]  = 0;
         m_act[i] = 0;
      end
      m_pend = 0;
      m_x1 = 0; m_x2 = 0; m_y1 = 0; m_y2 = 0;
   endtask

   task automatic model_step(longint x, bit fl, bit cp,
                             output longint y, output bit s);
      longint sum, r;
      if (fl) begin
         m_x1 = 0; m_x2 = 0; m_y1 = 0; m_y2 = 0;
      end
      if (m_pend) begin
         m_act  = m_sh;
         m_pend = 0;
      end
      if (cp) begin
         m_sh   = nc;
         m_pend = 1;
      end
      sum = m_act[0] * x + m_act[1] * m_x1 + m_act[2] * m_x2
          - m_act[3] * m_y1 - m_act[4] * m_y2;
      r = (sum + 32768) >>> 16;
      s = 1;
      if (r > 8388607)       y = 8388607;
      else if (r < -8388608) y = -8388608;
      else begin
         y = r;
         s = 0;
      end
      m_x2 = m_x1; m_x1 = x;
      m_y2 = m_y1; m_y1 = y;
   endtask

   task automatic drive_coef_bus();
      bus.b0_in = nc[0][23:0];
      bus.b1_in = nc[1][23:0];
      bus.b2_in = nc[2][23:0];
      bus.a1_in = nc[3][23:0];
      bus.a2_in = nc[4][23:0];
   endtask

   task automatic do_coef();
      @(negedge clk);
      drive_coef_bus();
      bus.coeff_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.coeff_valid = 1'b0;
      m_sh   = nc;
      m_pend = 1;
   endtask

   task automatic run_sample(string tag, logic [23:0] x,
                             bit fl, bit cp, bit use_exp,
                             logic [23:0] ey, bit es);
      longint my;
      bit ms;
      int lat;
      logic [23:0] exp_y;
      bit exp_s;
      @(negedge clk);
      check({tag, "_ready"}, 64'(bus.sample_ready), 64'd1);
      bus.sample_in    = x;
      bus.sample_valid = 1'b1;
      bus.flush        = fl;
      if (cp) begin
         drive_coef_bus();
         bus.coeff_valid = 1'b1;
      end
      @(posedge clk);
      #1;
      bus.sample_valid = 1'b0;
      bus.flush        = 1'b0;
      bus.coeff_valid  = 1'b0;
      model_step(sx(x), fl, cp, my, ms);
      exp_y = use_exp ? ey : my[23:0];
      exp_s = use_exp ? es : ms;
      lat = 0;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         if (bus.out_valid === 1'b1) begin
            lat = i;
            break;
         end
      end
      check({tag, "_latency"}, 64'(lat), 64'd7);
      check({tag, "_out"}, 64'(bus.sample_out), 64'(exp_y));
      check({tag, "_sat"}, 64'(bus.sat), 64'(exp_s));
      @(negedge clk);
      check({tag, "_pulse"}, 64'(bus.out_valid), 64'd0);
   endtask

   initial begin
      int seen;
      bit fl, cp;
      bus.coeff_valid  = 1'b0;
      bus.b0_in        = '0;
      bus.b1_in        = '0;
      bus.b2_in        = '0;
      bus.a1_in        = '0;
      bus.a2_in        = '0;
      bus.sample_in    = '0;
      bus.sample_valid = 1'b0;
      bus.flush        = 1'b0;
      model_reset();

      repeat (2) @(negedge clk);
      check("rst_ready", 64'(bus.sample_ready), 64'd0);
      check("rst_valid", 64'(bus.out_valid), 64'd0);
      check("rst_out", 64'(bus.sample_out), 64'd0);
      check("rst_sat", 64'(bus.sat), 64'd0);
      reset = 1'b1;
      #1;
      check("rel_ready", 64'(bus.sample_ready), 64'd1);

      nc = '{64'h10000, 0, 0, 0, 0};
      do_coef();
      run_sample("pass", 24'h100000, 0, 0, 1, 24'h100000, 0);

      nc = '{64'h8000, 64'h8000, 64'h8000, 0, 0};
      do_coef();
      run_sample("fir0", 24'h400000, 1, 0, 1, 24'h200000, 0);
      run_sample("fir1", 24'h000000, 0, 0, 1, 24'h200000, 0);
      run_sample("fir2", 24'h000000, 0, 0, 1, 24'h200000, 0);
      run_sample("fir3", 24'h000000, 0, 0, 1, 24'h000000, 0);

      nc = '{64'h10000, 0, 0, sx(24'hFF8000), 0};
      do_coef();
      run_sample("dec0", 24'h400000, 1, 0, 1, 24'h400000, 0);
      run_sample("dec1", 24'h000000, 0, 0, 1, 24'h200000, 0);
      run_sample("dec2", 24'h000000, 0, 0, 1, 24'h100000, 0);
      run_sample("dec3", 24'h000000, 0, 0, 1, 24'h080000, 0);

      nc = '{64'h20000, 0, 0, 0, 0};
      do_coef();
      run_sample("satp", 24'h600000, 1, 0, 1, 24'h7FFFFF, 1);
      run_sample("satn", 24'hA00000, 0, 0, 1, 24'h800000, 1);

      nc = '{64'h10000, 0, 0, 0, 0};
      do_coef();
      nc = '{64'h8000, 0, 0, 0, 0};
      run_sample("ct0", 24'h200000, 0, 1, 1, 24'h200000, 0);
      run_sample("ct1", 24'h200000, 0, 0, 1, 24'h100000, 0);

      // reset while the MAC schedule is at k=2
      @(negedge clk);
      bus.sample_in    = 24'h400000;
      bus.sample_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.sample_valid = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      model_reset();
      #1;
      check("mid_rst_ready", 64'(bus.sample_ready), 64'd0);
      check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.out_valid !== 1'b0) seen++;
      end
      check("mid_rst_no_out", 64'(seen), 64'd0);
      check("mid_rst_ready1", 64'(bus.sample_ready), 64'd1);
      nc = '{64'h10000, 0, 0, 0, 0};
      do_coef();
      run_sample("post_rst", 24'h100000, 0, 0, 1, 24'h100000, 0);

      for (int j = 0; j < 5; j++) nc[j] = rc();
      do_coef();
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            for (int j = 0; j < 5; j++) nc[j] = rc();
            do_coef();
         end
         cp = ($urandom_range(0, 5) == 0);
         if (cp)
            for (int j = 0; j < 5; j++) nc[j] = rc();
         fl = ($urandom_range(0, 4) == 0);
         run_sample("rnd", 24'($urandom), fl, cp, 0, 24'h0, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/biquad_iir_filter.md
Name: biquad_iir_filter

Overview:
- Single-section Direct Form I biquad IIR filter.
- Sits directly downstream of the coefficient unit. It captures the b0, b1, b2, a1 and a2 coefficients (Q8.16) on that unit's ready pulse, then filters a stream of signed Q1.23 audio samples.
- One shared multiplier runs over a fixed 5-cycle MAC schedule per sample, followed by round/saturate.
- Output feeds the downstream sample sink.

Parameters:
- SAMPLE_WIDTH, 24: sample and coefficient word width (samples Q1.23, coefficients Q8.16).
- FRAC_BITS, 16: coefficient fractional bits; product right-shift amount.
- ACC_WIDTH, 52: accumulator width; must be ≥ 2*SAMPLE_WIDTH+3.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- coeff_valid  in  1  one-cycle pulse: b0..a2 inputs valid (driven by the coefficient unit's ready).
- b0_in, b1_in, b2_in, a1_in, a2_in  in  SAMPLE_WIDTH each  signed Q8.16 coefficients.
- sample_in  in  SAMPLE_WIDTH  signed Q1.23 input sample.
- sample_valid  in  1  sample_in valid.
- sample_ready  out  1  block can accept a sample.
- flush  in  1  zero filter history (honoured only in IDLE).
- sample_out  out  SAMPLE_WIDTH  signed Q1.23 filtered sample.
- out_valid  out  1  one-cycle pulse: sample_out valid.
- sat  out  1  asserted with out_valid when the result was clipped.

Behaviour:
- Reset (async, reset=0): all registers clear.
  - sample_out=0, out_valid=0, sat=0, sample_ready=0 while in reset.
  - Shadow/active coefficients, pending flag, history x1, x2, y1, y2 and accumulator = 0.
  - After release: FSM in IDLE, sample_ready=1.
  - A reset mid-operation aborts the sample: no out_valid, history stays zero.
- Equation: y = b0*x0 + b1*x1 + b2*x2 - a1*y1 - a2*y2.
- Coefficient capture:
  - coeff_valid loads the shadow registers and sets pending, in any state.
  - On each sample accept edge, if pending=1, active<=shadow and pending clears. The accepted sample uses the new set.
  - If coeff_valid coincides with the accept edge, the accepted sample uses the prior shadow contents (loaded if pending). The new set stays pending for the next sample.
  - Coefficients never change mid-sample.
- Handshake: sample_ready=1 only in IDLE. Accept edge = sample_valid & sample_ready; x0 latched there.
- FSM:
  - IDLE -> MAC on accept.
  - MAC: 5 cycles, k=0..4. Products in order b0*x0, b1*x1, b2*x2, a1*y1, a2*y2. Feedback terms are subtracted. Accumulator cleared at accept.
  - ROUND (1 cycle): add 2^(FRAC_BITS-1), arithmetic shift right FRAC_BITS (round half up). Saturate to [0x800000, 0x7FFFFF].
    - Register sample_out and sat; set out_valid.
    - Update history x2<=x1, x1<=x0, y2<=y1, y1<=saturated y.
  - ROUND -> IDLE.
- Latency:
  - Accept at edge T. MAC edges T+1..T+5, ROUND edge T+6.
  - out_valid=1 for exactly the cycle after edge T+6.
  - Next accept is possible at edge T+7, giving a throughput of 1 sample per 7 cycles.
- Output: out_valid is a one-cycle pulse with no backpressure. sample_out holds its value until the next ROUND.
- Arithmetic: 24x24 signed products (48 bits, Q9.39), sign-extended into ACC_WIDTH. No intermediate overflow is possible.
- flush: in IDLE, clears x1, x2, y1, y2 next edge; ignored in other states. If flush and accept occur in the same IDLE cycle, flush wins, the sample is still accepted, and it is computed with zero history.

Test Plan:
- Passthrough: coeff_valid with b0=0x010000, others 0; sample 0x100000 -> sample_out=0x100000, out_valid exactly 7 cycles after accept edge, sat=0.
- FIR impulse: b0=b1=b2=0x008000, a=0; inputs 0x400000,0,0,0 -> 0x200000,0x200000,0x200000,0x000000.
- Feedback decay: b0=0x010000, a1=0xFF8000 (-0.5), others 0; impulse 0x400000 then zeros -> 0x400000,0x200000,0x100000,0x080000.
- Saturation: b0=0x020000; input 0x600000 -> 0x7FFFFF with sat=1; input 0xA00000 -> 0x800000 with sat=1.
- Coefficient timing: with b0=1.0 active, pulse coeff_valid b0=0x008000 on the same edge as accept of 0x200000 -> output 0x200000; next input 0x200000 -> 0x100000.
- Reset mid-MAC: accept 0x400000, assert reset at MAC k=2 -> no out_valid; after release sample_ready=1. With b0=1.0 reloaded, next input 0x100000 -> 0x100000, confirming zero history.
